rshift_pipe: RTL and testbench

RSHIFT_PIPE -- requirements
Module: rshift_pipe

---
 rtl/rshift_pipe.sv | 73 +++++++
 tb/tb_rshift_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rshift_pipe.sv
// Three-stage right-rotate pipeline for 8-bit words (rotate by 1, 2, then 4)
// with valid/ready flow control, a synchronous flush and an occupancy count.
module rshift_pipe (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x,
  input  logic [2:0] shift,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] y,
  output logic [1:0] occ
);

  // Handshake: a word moves across a boundary on a rising edge where the
  // sender's valid and the receiver's ready are both 1. in_ready never
  // depends on in_valid, and y/out_valid come straight from S3 registers.

  logic [7:0] d1, d2, d3;
  logic [1:0] sh1;
  logic       sh2;
  logic       v1, v2, v3;
  logic       load1, load2, load3;

  assign load3 = !v3 || out_ready;
  assign load2 = !v2 || load3;
  assign load1 = !v1 || load2;

  assign in_ready  = load1 && !flush;
  assign out_valid = v3;
  assign y         = d3;
  assign occ       = {1'b0, v1} + {1'b0, v2} + {1'b0, v3};

  // Flush clears every valid flag and blocks all transfers on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1  <= 8'h00;
      d2  <= 8'h00;
      d3  <= 8'h00;
      sh1 <= 2'b00;
      sh2 <= 1'b0;
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (load3) begin
        v3 <= v2;
        if (v2) d3 <= sh2 ? {d2[3:0], d2[7:4]} : d2;
      end
      if (load2) begin
        v2 <= v1;
        if (v1) begin
          d2  <= sh1[0] ? {d1[1:0], d1[7:2]} : d1;
          sh2 <= sh1[1];
        end
      end
      if (load1) begin
        v1 <= in_valid;
        if (in_valid) begin
          d1  <= shift[0] ? {x[0], x[7:1]} : x;
          sh1 <= shift[2:1];
        end
      end
    end
  end

endmodule

// File: tb/tb_rshift_pipe.sv
// Directed and randomised bench for rshift_pipe: hand-computed vectors plus
// a scoreboard that tracks every accepted word through to the output.
module tb_rshift_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] x = 8'h00;
  logic [2:0] shift = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] y;
  logic [1:0] occ;

  int n_checks = 0;
  int n_pass = 0;
  int n_out = 0;
  logic [7:0] exp_q[$];

  rshift_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .occ(occ)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [7:0] rotr(input logic [7:0] v, input logic [2:0] s);
    logic [15:0] t;
    t = {v, v} >> s;
    return t[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the word on the input until an edge accepts it.
  task automatic send(input logic [7:0] dx, input logic [2:0] ds);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1;
    x = dx;
    shift = ds;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    check("send_accept", acc, 1);
    in_valid = 1'b0;
  endtask

  // Scoreboard: inputs are stable at the falling edge, so the handshakes
  // seen there are exactly the ones the next rising edge will perform.
  always @(negedge clk) begin
    if (rst_n) begin
      check("occ_vs_model", occ, exp_q.size());
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_out++;
          if (exp_q.size() == 0) check("unexpected_out", 1, 0);
          else check("sb_y", y, exp_q.pop_front());
        end
        if (in_valid && in_ready) exp_q.push_back(rotr(x, shift));
      end
    end
  end

  logic [7:0] pv_x[4]   = '{8'h81, 8'h01, 8'hA5, 8'h3C};
  logic [2:0] pv_s[4]   = '{3'd1, 3'd3, 3'd4, 3'd0};
  logic [7:0] pv_exp[4] = '{8'hC0, 8'h20, 8'h5A, 8'h3C};

  initial begin
    time t0;
    int n0;

    // Reset and post-release state
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 8'h00);
    check("rst_occ", occ, 0);
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    // Directed vectors with latency: accept edge is the first of three
    for (int k = 0; k < 4; k++) begin
      send(pv_x[k], pv_s[k]);
      check("lat_e1_valid", out_valid, 0);
      tick();
      check("lat_e2_valid", out_valid, 0);
      tick();
      check("lat_e3_valid", out_valid, 1);
      check("pass_y", y, pv_exp[k]);
      tick();
      check("pass_drained", out_valid, 0);
    end

    // Full sweep back-to-back: one accept per cycle
    t0 = $time;
    n0 = n_out;
    for (int i = 0; i < 2048; i++) send(i[7:0], i[10:8]);
    check("sweep_cycles", 32'(($time - t0) / 10), 2048);
    repeat (4) tick();
    check("sweep_count", n_out - n0, 2048);
    check("sweep_empty", exp_q.size(), 0);

    // Backpressure
    out_ready = 1'b0;
    send(8'h01, 3'd1);
    send(8'h02, 3'd1);
    send(8'h04, 3'd1);
    in_valid = 1'b1;
    x = 8'h08;
    shift = 3'd1;
    #1;
    check("bp_occ", occ, 3);
    check("bp_in_ready", in_ready, 0);
    check("bp_y", y, 8'h80);
    repeat (2) begin
      tick();
      check("bp_hold_y", y, 8'h80);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_occ", occ, 3);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_y1", y, 8'h01);
    check("bp_occ_after", occ, 3);
    tick();
    check("bp_y2", y, 8'h02);
    tick();
    check("bp_y3", y, 8'h04);
    tick();
    check("bp_empty", out_valid, 0);

    // Flush with full pipe, input offered and output ready
    out_ready = 1'b0;
    send(8'h11, 3'd2);
    send(8'h22, 3'd5);
    send(8'h33, 3'd7);
    check("fl_full", occ, 3);
    in_valid = 1'b1;
    x = 8'h44;
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 0);
    n0 = n_out;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_occ", occ, 0);
    check("fl_out_valid", out_valid, 0);
    repeat (3) tick();
    check("fl_no_emerge", out_valid, 0);
    check("fl_delivered", n_out - n0, 0);

    // Asynchronous reset mid-stream with occ=2 and a valid output
    out_ready = 1'b0;
    send(8'h96, 3'd2);
    repeat (2) tick();
    send(8'h5C, 3'd6);
    check("rs_occ2", occ, 2);
    check("rs_valid_before", out_valid, 1);
    check("rs_y_before", y, 8'hA5);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rs_out_valid", out_valid, 0);
    check("rs_y", y, 8'h00);
    check("rs_occ", occ, 0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      check("rs_no_stale", out_valid, 0);
    end

    // Random valid/ready traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      x = 8'($urandom_range(0, 255));
      shift = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    check("rand_drained", exp_q.size(), 0);
    check("rand_idle", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
